// File: rtl/operand_fetch_sequencer.sv
// operand_fetch_sequencer
// Per-lane, per-operand-queue VRF read sequencer. Accepts a fetch command
// (start word address + word count) and issues one bank read request per
// cycle, throttled by a credit counter that mirrors the free slots of the
// downstream operand queue and by the bank arbiter grant.
//
// Optional feature: define ARA_OPSEQ_HAZARD_EN to add the read-after-write
// hazard ports (cmd_haz_i, wr_progress_i) and the WAIT_HAZ state. Without
// the macro every command goes straight to FETCH.
module operand_fetch_sequencer #(
   parameter int unsigned DataBufDepth = 5,
   parameter int unsigned VrfWords     = 256,
   parameter int unsigned LenWidth     = 16,
   parameter int unsigned AddrWidth    = $clog2(VrfWords),
   parameter int unsigned CredWidth    = $clog2(DataBufDepth + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [AddrWidth-1:0] cmd_addr_i,
   input  logic [LenWidth-1:0]  cmd_len_i,
`ifdef ARA_OPSEQ_HAZARD_EN
   input  logic                 cmd_haz_i,
   input  logic [LenWidth-1:0]  wr_progress_i,
`endif
   output logic                 vrf_req_o,
   output logic [AddrWidth-1:0] vrf_addr_o,
   input  logic                 vrf_gnt_i,
   output logic                 operand_issued_o,
   input  logic                 operand_consumed_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [CredWidth-1:0] credits_o
);

   localparam logic [CredWidth-1:0] CredMax = CredWidth'(DataBufDepth);

`ifdef ARA_OPSEQ_HAZARD_EN
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FETCH    = 2'd1,
      WAIT_HAZ = 2'd2
   } state_e;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1
   } state_e;
`endif

   state_e               state_q;
   logic [AddrWidth-1:0] addr_q;
   logic [LenWidth-1:0]  remain_q;
   logic                 zero_done_q;
   logic [CredWidth-1:0] credits_q, credits_d;
`ifdef ARA_OPSEQ_HAZARD_EN
   logic                 haz_q;
   logic [LenWidth-1:0]  idx_q;
`endif

   logic haz_ok;
   logic req;
   logic issue;
   logic last_word;

   // Hazard gate: word k of a dependent command may only be read once the
   // producer has written more than k words.
`ifdef ARA_OPSEQ_HAZARD_EN
   assign haz_ok = !haz_q || (wr_progress_i > idx_q);
`else
   assign haz_ok = 1'b1;
`endif

   // Request is live in FETCH whenever a queue slot is free. Credits only
   // drop on an issue, and write progress is monotonic, so an ungranted
   // request is never withdrawn.
   assign req       = (state_q == FETCH) && (credits_q != '0) && haz_ok;
   assign issue     = req && vrf_gnt_i;
   assign last_word = (remain_q == LenWidth'(1));

   assign cmd_ready_o      = (state_q == IDLE);
   assign busy_o           = (state_q != IDLE);
   assign vrf_req_o        = req;
   assign vrf_addr_o       = addr_q;
   assign operand_issued_o = issue;
   // Normal completion flags the cycle of the last issue; a zero-length
   // command flags the cycle after its acceptance.
   assign done_o           = (issue && last_word) || zero_done_q;
   assign credits_o        = credits_q;

   // Credit bookkeeping: issue takes a slot, consume returns one; both
   // together cancel. A consume into a full counter is dropped (saturate).
   always_comb begin
      credits_d = credits_q;
      if (issue && !operand_consumed_i) begin
         credits_d = credits_q - CredWidth'(1);
      end else if (!issue && operand_consumed_i && (credits_q != CredMax)) begin
         credits_d = credits_q + CredWidth'(1);
      end
   end

   // Credit register; persists across commands and is only restored by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         credits_q <= CredMax;
      end else begin
         credits_q <= credits_d;
      end
   end

   // Command FSM: latches the command, walks the address and remaining count
   // on every issue and returns to IDLE after the last word.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remain_q    <= '0;
         zero_done_q <= 1'b0;
`ifdef ARA_OPSEQ_HAZARD_EN
         haz_q       <= 1'b0;
         idx_q       <= '0;
`endif
      end else begin
         zero_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cmd_valid_i) begin
                  addr_q   <= cmd_addr_i;
                  remain_q <= cmd_len_i;
`ifdef ARA_OPSEQ_HAZARD_EN
                  haz_q    <= cmd_haz_i;
                  idx_q    <= '0;
`endif
                  if (cmd_len_i == '0) begin
                     zero_done_q <= 1'b1;
`ifdef ARA_OPSEQ_HAZARD_EN
                  end else if (cmd_haz_i) begin
                     state_q <= WAIT_HAZ;
`endif
                  end else begin
                     state_q <= FETCH;
                  end
               end
            end
`ifdef ARA_OPSEQ_HAZARD_EN
            WAIT_HAZ: begin
               if (wr_progress_i != '0) begin
                  state_q <= FETCH;
               end
            end
`endif
            FETCH: begin
               if (issue) begin
                  // Power-of-two VRF: natural overflow wraps VrfWords-1 to 0.
                  addr_q   <= addr_q + AddrWidth'(1);
                  remain_q <= remain_q - LenWidth'(1);
`ifdef ARA_OPSEQ_HAZARD_EN
                  idx_q    <= idx_q + LenWidth'(1);
`endif
                  if (last_word) begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A consume while every slot is already free means the queue popped an
   // element that was never issued to it.
   a_no_consume_when_full : assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      !(operand_consumed_i && !issue && (credits_q == CredMax))
   );

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Directed bench for operand_fetch_sequencer (DataBufDepth=5, VrfWords=256).
// Each cycle's observable outputs are packed as
// {cmd_ready, busy, vrf_req, issued, done, vrf_addr[7:0], credits[2:0]}.
module tb_operand_fetch_sequencer;

   localparam int unsigned DataBufDepth = 5;
   localparam int unsigned VrfWords     = 256;
   localparam int unsigned LenWidth     = 16;
   localparam int unsigned AddrWidth    = 8;
   localparam int unsigned CredWidth    = 3;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [AddrWidth-1:0] cmd_addr;
   logic [LenWidth-1:0]  cmd_len;
`ifdef ARA_OPSEQ_HAZARD_EN
   logic                 cmd_haz;
   logic [LenWidth-1:0]  wr_progress;
`endif
   logic                 vrf_req;
   logic [AddrWidth-1:0] vrf_addr;
   logic                 vrf_gnt;
   logic                 issued;
   logic                 consumed;
   logic                 busy;
   logic                 done;
   logic [CredWidth-1:0] credits;

   logic [15:0] obs;
   logic [15:0] exp;

   int n_tests = 0;
   int n_fail  = 0;

   assign obs = {cmd_ready, busy, vrf_req, issued, done, vrf_addr, credits};

   always #5 clk = ~clk;

   operand_fetch_sequencer #(
      .DataBufDepth(DataBufDepth),
      .VrfWords    (VrfWords),
      .LenWidth    (LenWidth)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .cmd_valid_i       (cmd_valid),
      .cmd_ready_o       (cmd_ready),
      .cmd_addr_i        (cmd_addr),
      .cmd_len_i         (cmd_len),
`ifdef ARA_OPSEQ_HAZARD_EN
      .cmd_haz_i         (cmd_haz),
      .wr_progress_i     (wr_progress),
`endif
      .vrf_req_o         (vrf_req),
      .vrf_addr_o        (vrf_addr),
      .vrf_gnt_i         (vrf_gnt),
      .operand_issued_o  (issued),
      .operand_consumed_i(consumed),
      .busy_o            (busy),
      .done_o            (done),
      .credits_o         (credits)
   );

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Reset and leave the bench at posedge+1 with all inputs idle (cycle 0).
   task automatic do_reset();
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      vrf_gnt   = 1'b0;
      consumed  = 1'b0;
`ifdef ARA_OPSEQ_HAZARD_EN
      cmd_haz     = 1'b0;
      wr_progress = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      vrf_gnt   = 1'b1;
      consumed  = 1'b0;
      @(negedge clk);
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd5};
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL reset: got %h expected %h", obs, exp);
      end
   endtask

   // addr=10 len=4, grant always, consume alongside every issue.
   task automatic test_stream();
      do_reset();
      cmd_valid = 1'b1;
      cmd_addr  = 8'd10;
      cmd_len   = 16'd4;
      vrf_gnt   = 1'b1;
      @(negedge clk);
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd5};
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL stream c0: got %h expected %h", obs, exp);
      end
      for (int k = 1; k <= 4; k++) begin
         next_cycle();
         cmd_valid = 1'b0;
         consumed  = 1'b1;
         @(negedge clk);
         exp = {1'b0, 1'b1, 1'b1, 1'b1, (k == 4), 8'(9 + k), 3'd5};
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL stream c%0d: got %h expected %h", k, obs, exp);
         end
      end
      next_cycle();
      consumed = 1'b0;
      @(negedge clk);
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd14, 3'd5};
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL stream c5: got %h expected %h", obs, exp);
      end
   endtask

   // len=8 with no consume: five issues drain the credits, then one consume
   // buys exactly one more issue. A different command is held valid while
   // busy and must be ignored.
   task automatic test_credit_stall();
      int n_iss;
      n_iss = 0;
      do_reset();
      cmd_valid = 1'b1;
      cmd_addr  = 8'd20;
      cmd_len   = 16'd8;
      vrf_gnt   = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         next_cycle();
         cmd_addr = 8'd99;
         cmd_len  = 16'd1;
         consumed = (k == 7);
         @(negedge clk);
         if (issued === 1'b1) n_iss++;
         if (k <= 5)
            exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'(19 + k), 3'(6 - k)};
         else if (k <= 7)
            exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd25, 3'd0};
         else if (k == 8)
            exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd25, 3'd1};
         else
            exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd26, 3'd0};
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL credit_stall c%0d: got %h expected %h", k, obs, exp);
         end
         if (k == 7) begin
            n_tests++;
            if (n_iss != 5) begin
               n_fail++;
               $display("FAIL credit_stall issues_before_consume: got %0d expected 5", n_iss);
            end
         end
      end
      n_tests++;
      if (n_iss != 6) begin
         n_fail++;
         $display("FAIL credit_stall issues_total: got %0d expected 6", n_iss);
      end
      cmd_valid = 1'b0;
   endtask

   // addr=254 len=4 with grant only on even cycles: 254,255,0,1, each
   // address held through its ungranted cycle.
   task automatic test_wrap_arb();
      logic [7:0] a;
      logic [2:0] cr;
      int n_iss;
      a = 8'd254;
      cr = 3'd5;
      n_iss = 0;
      do_reset();
      cmd_valid = 1'b1;
      cmd_addr  = 8'd254;
      cmd_len   = 16'd4;
      for (int k = 1; k <= 8; k++) begin
         next_cycle();
         cmd_valid = 1'b0;
         vrf_gnt   = ((k % 2) == 0);
         @(negedge clk);
         if (issued === 1'b1) n_iss++;
         exp = {1'b0, 1'b1, 1'b1, vrf_gnt, (k == 8), a, cr};
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL wrap_arb c%0d: got %h expected %h", k, obs, exp);
         end
         if ((k % 2) == 0) begin
            a  = a + 8'd1;
            cr = cr - 3'd1;
         end
      end
      next_cycle();
      vrf_gnt = 1'b0;
      @(negedge clk);
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 3'd1};
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL wrap_arb idle: got %h expected %h", obs, exp);
      end
      n_tests++;
      if (n_iss != 4) begin
         n_fail++;
         $display("FAIL wrap_arb issues: got %0d expected 4", n_iss);
      end
   endtask

   // len=0 completes without a request; then a 2-word command where the
   // second issue coincides with a consume.
   task automatic test_zero_len_simul();
      do_reset();
      cmd_valid = 1'b1;
      cmd_addr  = 8'd7;
      cmd_len   = 16'd0;
      vrf_gnt   = 1'b1;
      next_cycle();
      cmd_valid = 1'b0;
      @(negedge clk);
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 3'd5};
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL zero_len done: got %h expected %h", obs, exp);
      end
      next_cycle();
      cmd_valid = 1'b1;
      cmd_addr  = 8'd30;
      cmd_len   = 16'd2;
      @(negedge clk);
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 3'd5};
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL zero_len after: got %h expected %h", obs, exp);
      end
      next_cycle();
      cmd_valid = 1'b0;
      @(negedge clk);
      exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd30, 3'd5};
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL simul c1: got %h expected %h", obs, exp);
      end
      next_cycle();
      consumed = 1'b1;
      @(negedge clk);
      exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd31, 3'd4};
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL simul c2: got %h expected %h", obs, exp);
      end
      next_cycle();
      consumed = 1'b0;
      @(negedge clk);
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd32, 3'd4};
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL simul credits: got %h expected %h", obs, exp);
      end
   endtask

   // Reset after two of six issues; a fresh command afterwards starts at its
   // own address with full credits.
   task automatic test_reset_mid();
      do_reset();
      cmd_valid = 1'b1;
      cmd_addr  = 8'd40;
      cmd_len   = 16'd6;
      vrf_gnt   = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         next_cycle();
         cmd_valid = 1'b0;
         @(negedge clk);
         exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'(39 + k), 3'(6 - k)};
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_mid c%0d: got %h expected %h", k, obs, exp);
         end
      end
      next_cycle();
      rst_n = 1'b0;
      @(negedge clk);
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd5};
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL reset_mid in_reset: got %h expected %h", obs, exp);
      end
      next_cycle();
      rst_n     = 1'b1;
      cmd_valid = 1'b1;
      cmd_addr  = 8'd100;
      cmd_len   = 16'd1;
      @(negedge clk);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL reset_mid released: got %h expected %h", obs, exp);
      end
      next_cycle();
      cmd_valid = 1'b0;
      @(negedge clk);
      exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd100, 3'd5};
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL reset_mid new_cmd: got %h expected %h", obs, exp);
      end
      next_cycle();
      @(negedge clk);
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd101, 3'd4};
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL reset_mid new_end: got %h expected %h", obs, exp);
      end
   endtask

`ifdef ARA_OPSEQ_HAZARD_EN
   // Dependent len=3 command: progress 0 -> 1 -> 3.
   task automatic test_hazard();
      logic [15:0] tbl [1:8];
      tbl[1] = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd50, 3'd5};
      tbl[2] = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd50, 3'd5};
      tbl[3] = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd50, 3'd5};
      tbl[4] = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd50, 3'd5};
      tbl[5] = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd51, 3'd4};
      tbl[6] = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd51, 3'd4};
      tbl[7] = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd52, 3'd3};
      tbl[8] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd53, 3'd2};
      do_reset();
      cmd_valid   = 1'b1;
      cmd_haz     = 1'b1;
      cmd_addr    = 8'd50;
      cmd_len     = 16'd3;
      vrf_gnt     = 1'b1;
      wr_progress = 16'd0;
      for (int k = 1; k <= 8; k++) begin
         next_cycle();
         cmd_valid = 1'b0;
         cmd_haz   = 1'b0;
         if (k == 3) wr_progress = 16'd1;
         if (k == 6) wr_progress = 16'd3;
         @(negedge clk);
         exp = tbl[k];
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL hazard c%0d: got %h expected %h", k, obs, exp);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_credit_stall();
      test_wrap_arb();
      test_zero_len_simul();
      test_reset_mid();
`ifdef ARA_OPSEQ_HAZARD_EN
      test_hazard();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_fetch_sequencer.md
Name: operand_fetch_sequencer

Overview:
Per-lane, per-operand-queue read sequencer. It accepts a fetch command (VRF word address and word count) and issues one VRF bank read request per cycle. Issue is throttled by a credit counter that mirrors the free slots of the downstream operand queue, and by the bank arbiter grant. One instance sits between the lane sequencer and each operand queue. It drives that queue's operand_issued strobe.

Parameters:
DataBufDepth, 5, slot count of the downstream operand queue (initial credits, >=1)
VrfWords, 256, 64-bit words in the lane VRF (power of two)
LenWidth, 16, width of the word-count field
AddrWidth, $clog2(VrfWords), derived VRF word address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  fetch command valid
cmd_ready_o  out  1  sequencer can accept a command
cmd_addr_i  in  AddrWidth  first VRF word address
cmd_len_i  in  LenWidth  number of 64-bit words to fetch
vrf_req_o  out  1  read request to bank arbiter
vrf_addr_o  out  AddrWidth  read address
vrf_gnt_i  in  1  arbiter grant (same cycle as request)
operand_issued_o  out  1  pulse: one read issued toward the queue
operand_consumed_i  in  1  pulse: queue popped one element (frees a credit)
busy_o  out  1  command in progress
done_o  out  1  one-cycle pulse when the last word is issued
credits_o  out  $clog2(DataBufDepth+1)  current credit count (debug)

Behaviour:
- Reset values: cmd_ready_o=1, vrf_req_o=0, vrf_addr_o=0, operand_issued_o=0, busy_o=0, done_o=0, credits_o=DataBufDepth. FSM=IDLE. Counters are cleared.
- FSM states: IDLE, FETCH, WAIT_HAZ (WAIT_HAZ exists only with the optional feature).
- IDLE: cmd_ready_o=1. A handshake (cmd_valid_i & cmd_ready_o) latches addr and len.
  - If len==0: stay in IDLE, pulse done_o on the next cycle, never assert vrf_req_o.
  - Otherwise go to FETCH (or WAIT_HAZ).
- FETCH: cmd_ready_o=0, busy_o=1.
  - vrf_req_o = (credits>0). vrf_addr_o = current address (registered).
  - The first request appears the cycle after cmd acceptance.
  - Issue event = vrf_req_o & vrf_gnt_i. On issue:
    - operand_issued_o=1 in the same cycle.
    - Address increments by 1 and wraps from VrfWords-1 to 0.
    - Remaining count decrements.
  - When the last word issues, done_o pulses in that same cycle and the FSM returns to IDLE next cycle. cmd_ready_o is high again in that next cycle. No back-to-back bypass.
- vrf_req_o never drops without a grant. If credits>0 and the request is not granted, it is held with a stable address.
- Credits:
  - Decrement on issue, increment on operand_consumed_i.
  - Both in the same cycle: unchanged.
  - Credits are tracked across commands and are not reloaded on cmd accept.
  - At 0 credits, vrf_req_o=0 the same cycle. When a consume arrives, the request resumes the next cycle.
  - operand_consumed_i at credits==DataBufDepth is illegal: credits saturate, and a simulation assertion fires.
- Max throughput: 1 word/cycle while credits>0 and granted.
- Reset mid-command: immediate return to reset values, with no done_o pulse. The command is lost.
- cmd_valid_i while busy: ignored until cmd_ready_o=1. cmd fields need be stable only during the handshake.

Optional Feature:
Macro ARA_OPSEQ_HAZARD_EN.
- With the macro, extra ports are added:
  - cmd_haz_i (1): the command depends on an in-flight write.
  - wr_progress_i (LenWidth): words written so far by the producer, monotonic per command.
  - A cmd with cmd_haz_i=1 enters WAIT_HAZ.
  - In WAIT_HAZ and FETCH, the word with index k may issue only when wr_progress_i > k. Otherwise vrf_req_o=0.
  - WAIT_HAZ moves to FETCH once wr_progress_i>0.
- Without the macro: the ports and the WAIT_HAZ state are absent, and every command goes directly to FETCH.

Test Plan:
- Stream: DataBufDepth=5, cmd addr=10 len=4, gnt always 1, consume every cycle → vrf_addr 10,11,12,13 on cycles 1-4, four issued pulses, done_o on cycle 4, cmd_ready_o=1 on cycle 5.
- Credit stall: len=8, no consume → exactly 5 issues then vrf_req_o=0 and credits_o=0. One consume pulse → one more issue the next cycle.
- Wrap and arbitration: VrfWords=256, addr=254, len=4, gnt low on alternate cycles → addresses 254,255,0,1. Address is held during non-grant cycles. Four issues total.
- Zero length and simultaneous events: len=0 → done_o pulse next cycle, no request. Issue+consume in the same cycle → credits_o unchanged.
- Reset mid-command: assert rst_ni=0 after 2 of 6 issues → all outputs at reset values, credits_o=5, no done_o pulse. A new cmd after release starts at its own addr.
- Hazard (ARA_OPSEQ_HAZARD_EN): cmd_haz_i=1, len=3, wr_progress_i 0→1→3 over cycles → no request while 0. One issue after it reaches 1. Remaining issues after it reaches 3.
